// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it to the register array, serves two bypassed read ports and counts commits.
module wb_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    reg_write,
    input  logic                    mem_to_reg,
    input  logic                    JALen,
    input  logic [DW-1:0]           read_data,
    input  logic [DW-1:0]           result,
    input  logic [DW-1:0]           nextPC,
    input  logic [$clog2(NREG)-1:0] reg_wr_sel,
    input  logic [$clog2(NREG)-1:0] rd1_sel,
    input  logic [$clog2(NREG)-1:0] rd2_sel,
    output logic [DW-1:0]           rd1_data,
    output logic [DW-1:0]           rd2_data,
    output logic [DW-1:0]           wb_data,
    output logic                    wb_valid,
    output logic [$clog2(NREG)-1:0] wb_last_sel,
    output logic [15:0]             wr_count
);

    logic [DW-1:0] regs [NREG];
    logic          commit;

    // The jump link value wins over a load, which wins over the ALU result.
    always_comb begin
        wb_data = result;
        if (JALen)
            wb_data = nextPC;
        else if (mem_to_reg)
            wb_data = read_data;
    end

    assign commit = en & reg_write & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            wb_valid    <= 1'b0;
            wb_last_sel <= '0;
            wr_count    <= '0;
        end else begin
            wb_valid <= commit;
            if (commit) begin
                regs[reg_wr_sel] <= wb_data;
                wb_last_sel      <= reg_wr_sel;
                if (wr_count != 16'hFFFF)
                    wr_count <= wr_count + 16'd1;
            end
        end
    end

    // Same-cycle bypass lets decode see a value that is only committed at the next edge.
    always_comb begin
        rd1_data = regs[rd1_sel];
        rd2_data = regs[rd2_sel];
        if (commit && (rd1_sel == reg_wr_sel))
            rd1_data = wb_data;
        if (commit && (rd2_sel == reg_wr_sel))
            rd2_data = wb_data;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes hand-computed expectations into a
// scoreboard queue and a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst, en, reg_write, mem_to_reg, JALen;
    logic [15:0] read_data, result, nextPC;
    logic [2:0]  reg_wr_sel, rd1_sel, rd2_sel;
    logic [15:0] rd1_data, rd2_data, wb_data, wr_count;
    logic        wb_valid;
    logic [2:0]  wb_last_sel;

    int asserts = 0;
    int fails   = 0;

    typedef enum {S_RD1, S_RD2, S_WBD, S_VALID, S_LAST, S_CNT} sig_e;
    typedef struct {
        sig_e        sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    wb_regfile #(.DW(16), .NREG(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .JALen      (JALen),
        .read_data  (read_data),
        .result     (result),
        .nextPC     (nextPC),
        .reg_wr_sel (reg_wr_sel),
        .rd1_sel    (rd1_sel),
        .rd2_sel    (rd2_sel),
        .rd1_data   (rd1_data),
        .rd2_data   (rd2_data),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .wb_last_sel(wb_last_sel),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(en === 1'b1 && $isunknown(reg_write)))
            else $error("[TB] reg_write is X while en=1");
    end

    // Monitor: outputs are stable half a cycle after the stimulus edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.sig)
                S_RD1:   act = rd1_data;
                S_RD2:   act = rd2_data;
                S_WBD:   act = wb_data;
                S_VALID: act = {15'd0, wb_valid};
                S_LAST:  act = {13'd0, wb_last_sel};
                default: act = wr_count;
            endcase
            asserts++;
            if (act !== e.exp) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rw,
                                 input logic jal, input logic mtr,
                                 input logic [15:0] res, input logic [15:0] rdat,
                                 input logic [15:0] npc, input logic [2:0] wsel,
                                 input logic [2:0] r1, input logic [2:0] r2);
        rst        = r;
        en         = e;
        reg_write  = rw;
        JALen      = jal;
        mem_to_reg = mtr;
        result     = res;
        read_data  = rdat;
        nextPC     = npc;
        reg_wr_sel = wsel;
        rd1_sel    = r1;
        rd2_sel    = r2;
    endtask

    task automatic checkOutput(input sig_e s, input logic [15:0] v, input string n);
        exp_t e;
        e.sig  = s;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    initial begin
        // Reset held two cycles with a commit attempt pending.
        applyStimulus(1, 1, 1, 0, 0, 16'hBEEF, 16'h0, 16'h0, 3'd3, 3'd3, 3'd0);
        tick();
        checkOutput(S_RD1, 16'h0000, "rst_rd1_no_bypass");
        checkOutput(S_WBD, 16'hBEEF, "rst_wb_data");
        checkOutput(S_VALID, 16'd0, "rst_valid");
        checkOutput(S_CNT, 16'd0, "rst_count");
        checkOutput(S_LAST, 16'd0, "rst_last_sel");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 16'hBEEF, 16'h0, 16'h0, 3'd3, 3'd3, 3'd0);
        checkOutput(S_RD1, 16'h0000, "post_rst_rd1_r3");
        checkOutput(S_VALID, 16'd0, "post_rst_valid");
        checkOutput(S_CNT, 16'd0, "post_rst_count");
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0, 3'(i), 3'(i + 4));
            checkOutput(S_RD1, 16'h0000, $sformatf("rst_reg%0d", i));
            checkOutput(S_RD2, 16'h0000, $sformatf("rst_reg%0d", i + 4));
            tick();
        end

        // Writeback source select into reg5.
        applyStimulus(0, 1, 1, 1, 1, 16'h1111, 16'h2222, 16'h3333, 3'd5, 3'd5, 3'd0);
        checkOutput(S_WBD, 16'h3333, "sel_jal_wb");
        checkOutput(S_RD1, 16'h3333, "sel_jal_bypass");
        tick();
        applyStimulus(0, 1, 0, 0, 1, 16'h1111, 16'h2222, 16'h3333, 3'd5, 3'd5, 3'd0);
        checkOutput(S_RD1, 16'h3333, "sel_jal_array");
        checkOutput(S_VALID, 16'd1, "sel_jal_valid");
        checkOutput(S_LAST, 16'd5, "sel_jal_last");
        checkOutput(S_CNT, 16'd1, "sel_jal_count");
        tick();
        applyStimulus(0, 1, 1, 0, 1, 16'h1111, 16'h2222, 16'h3333, 3'd5, 3'd5, 3'd0);
        checkOutput(S_WBD, 16'h2222, "sel_mem_wb");
        checkOutput(S_VALID, 16'd0, "idle_valid");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 16'h1111, 16'h2222, 16'h3333, 3'd5, 3'd5, 3'd0);
        checkOutput(S_RD1, 16'h2222, "sel_mem_array");
        checkOutput(S_CNT, 16'd2, "sel_mem_count");
        tick();
        applyStimulus(0, 1, 1, 0, 0, 16'h1111, 16'h2222, 16'h3333, 3'd5, 3'd5, 3'd0);
        checkOutput(S_WBD, 16'h1111, "sel_alu_wb");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 16'h1111, 16'h2222, 16'h3333, 3'd5, 3'd5, 3'd0);
        checkOutput(S_RD1, 16'h1111, "sel_alu_array");
        checkOutput(S_CNT, 16'd3, "sel_alu_count");
        tick();

        // Bypass on both ports, then independent hit/miss.
        applyStimulus(0, 1, 1, 0, 0, 16'hA5A5, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
        checkOutput(S_RD1, 16'hA5A5, "byp_rd1");
        checkOutput(S_RD2, 16'hA5A5, "byp_rd2");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
        checkOutput(S_RD1, 16'hA5A5, "byp_array_rd1");
        checkOutput(S_RD2, 16'hA5A5, "byp_array_rd2");
        checkOutput(S_LAST, 16'd2, "byp_last");
        checkOutput(S_CNT, 16'd4, "byp_count");
        tick();
        applyStimulus(0, 1, 1, 0, 0, 16'h0042, 16'h0, 16'h0, 3'd6, 3'd6, 3'd5);
        checkOutput(S_RD1, 16'h0042, "byp_hit_rd1");
        checkOutput(S_RD2, 16'h1111, "byp_miss_rd2");
        tick();

        // Stall with a write request pending.
        applyStimulus(0, 0, 1, 0, 0, 16'h7777, 16'h0, 16'h0, 3'd4, 3'd4, 3'd6);
        checkOutput(S_RD1, 16'h0000, "stall_no_bypass");
        checkOutput(S_WBD, 16'h7777, "stall_wb_data");
        checkOutput(S_VALID, 16'd1, "pre_stall_valid");
        checkOutput(S_CNT, 16'd5, "pre_stall_count");
        tick();
        checkOutput(S_RD1, 16'h0000, "stall_rd1");
        checkOutput(S_RD2, 16'h0042, "stall_rd2");
        checkOutput(S_VALID, 16'd0, "stall_valid");
        checkOutput(S_LAST, 16'd6, "stall_last_hold");
        checkOutput(S_CNT, 16'd5, "stall_count");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 16'h7777, 16'h0, 16'h0, 3'd4, 3'd4, 3'd6);
        checkOutput(S_RD1, 16'h0000, "stall_reg4_unchanged");
        checkOutput(S_CNT, 16'd5, "stall_count_after");
        tick();

        // Reset arriving together with a commit.
        applyStimulus(0, 1, 1, 0, 0, 16'h00FF, 16'h0, 16'h0, 3'd1, 3'd1, 3'd5);
        checkOutput(S_RD1, 16'h00FF, "mid_write_bypass");
        tick();
        applyStimulus(1, 1, 1, 0, 0, 16'hFFFF, 16'h0, 16'h0, 3'd1, 3'd1, 3'd5);
        checkOutput(S_RD1, 16'h00FF, "mid_rst_no_bypass");
        checkOutput(S_LAST, 16'd1, "mid_pre_last");
        checkOutput(S_CNT, 16'd6, "mid_pre_count");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 16'hFFFF, 16'h0, 16'h0, 3'd1, 3'd1, 3'd5);
        checkOutput(S_RD1, 16'h0000, "mid_rst_reg1");
        checkOutput(S_RD2, 16'h0000, "mid_rst_reg5");
        checkOutput(S_VALID, 16'd0, "mid_rst_valid");
        checkOutput(S_LAST, 16'd0, "mid_rst_last");
        checkOutput(S_CNT, 16'd0, "mid_rst_count");
        tick();

        // Counter saturation: preload to FFFE with real commits, then three more.
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 16'(i), 16'h0, 16'h0, 3'd7, 3'd0, 3'd0);
            tick();
        end
        applyStimulus(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd7, 3'd7, 3'd0);
        checkOutput(S_CNT, 16'hFFFE, "sat_preload");
        checkOutput(S_RD1, 16'hFFFD, "sat_reg7");
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 3'd7, 3'd0, 3'd0);
            tick();
            checkOutput(S_CNT, 16'hFFFF, $sformatf("sat_commit%0d", i));
        end
        applyStimulus(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd7, 3'd0, 3'd0);
        tick();
        checkOutput(S_CNT, 16'hFFFF, "sat_hold");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
